// File: rtl/eq_bist.sv
// Exhaustive BIST sweep for the WIDTH-bit equality comparator; checks dut_equal against a == b.
// Optional first-failure capture is built only when EQ_BIST_FIRST_FAIL_EN is defined.
module eq_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  input  logic               dut_equal,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output logic               fail_equal
);

  localparam int CW = 2 * WIDTH;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_APPLY  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CW:0]   err_q, err_d;
  logic          mismatch;
  logic          accept;

  // Operands come straight from the vector counter: {a, b} with b fastest.
  assign dut_a     = cnt_q[CW-1:WIDTH];
  assign dut_b     = cnt_q[WIDTH-1:0];
  assign busy      = (state_q == S_APPLY) || (state_q == S_SAMPLE);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign mismatch  = (state_q == S_SAMPLE) && (dut_equal != (dut_a == dut_b));
  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_APPLY;
          cnt_d    = '0;
          settle_d = '0;
          err_d    = '0;
        end
      end
      S_APPLY: begin
        if (settle_q == SW'(SETTLE - 1)) begin
          state_d  = S_SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_SAMPLE: begin
        if (mismatch) err_d = err_q + (CW + 1)'(1);
        settle_d = '0;
        if (cnt_q == '1) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          state_d = S_APPLY;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      err_q    <= err_d;
    end
  end

`ifdef EQ_BIST_FIRST_FAIL_EN
  logic             fail_valid_q, fail_valid_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic             fail_equal_q, fail_equal_d;

  always_comb begin
    fail_valid_d = fail_valid_q;
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;
    fail_equal_d = fail_equal_q;
    if (accept) begin
      fail_valid_d = 1'b0;
      fail_a_d     = '0;
      fail_b_d     = '0;
      fail_equal_d = 1'b0;
    end else if (mismatch && !fail_valid_q) begin
      fail_valid_d = 1'b1;
      fail_a_d     = dut_a;
      fail_b_d     = dut_b;
      fail_equal_d = dut_equal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_equal_q <= 1'b0;
    end else begin
      fail_valid_q <= fail_valid_d;
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
      fail_equal_q <= fail_equal_d;
    end
  end

  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign fail_equal = fail_equal_q;
`else
  assign fail_valid = 1'b0;
  assign fail_a     = '0;
  assign fail_b     = '0;
  assign fail_equal = 1'b0;
`endif

endmodule

// File: tb/tb_eq_bist.sv
// Directed bench for eq_bist: good / stuck / inverted comparator models, reset and restart behaviour.
module tb_eq_bist;

  logic       clk;
  logic       reset;
  logic       start1, start3;
  int         mode;
  int         n_checks;
  int         n_fail;

  logic [3:0] dut_a1, dut_b1, fail_a1, fail_b1;
  logic       dut_equal1, busy1, done1, pass1, fail_valid1, fail_equal1;
  logic [8:0] err1;
  logic [3:0] dut_a3, dut_b3, fail_a3, fail_b3;
  logic       dut_equal3, busy3, done3, pass3, fail_valid3, fail_equal3;
  logic [8:0] err3;

  eq_bist #(.WIDTH(4), .SETTLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .dut_a(dut_a1), .dut_b(dut_b1), .dut_equal(dut_equal1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fail_valid1), .fail_a(fail_a1), .fail_b(fail_b1), .fail_equal(fail_equal1)
  );

  eq_bist #(.WIDTH(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .dut_a(dut_a3), .dut_b(dut_b3), .dut_equal(dut_equal3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_valid(fail_valid3), .fail_a(fail_a3), .fail_b(fail_b3), .fail_equal(fail_equal3)
  );

  // Comparator under test: 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 inverted.
  always_comb begin
    case (mode)
      1:       begin dut_equal1 = 1'b0;                dut_equal3 = 1'b0; end
      2:       begin dut_equal1 = 1'b1;                dut_equal3 = 1'b1; end
      3:       begin dut_equal1 = !(dut_a1 == dut_b1); dut_equal3 = !(dut_a3 == dut_b3); end
      default: begin dut_equal1 = (dut_a1 == dut_b1);  dut_equal3 = (dut_a3 == dut_b3); end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0; mode = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n_checks++;
    if ({dut_a1, dut_b1, busy1, done1, pass1, err1, fail_valid1, fail_a1, fail_b1, fail_equal1} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs1: got busy=%b done=%b pass=%b err=%0d a=%0d b=%0d fv=%b, required all 0",
               busy1, done1, pass1, err1, dut_a1, dut_b1, fail_valid1);
    end
    n_checks++;
    if ({dut_a3, dut_b3, busy3, done3, pass3, err3, fail_valid3} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs3: got busy=%b done=%b err=%0d, required all 0", busy3, done3, err3);
    end
    repeat (2) @(posedge clk);
  endtask

  // Runs one SETTLE=1 sweep with the given comparator model and checks the result.
  task automatic run_sweep(input string name, input int mode_in, input int exp_err,
                           input logic [3:0] exp_fa, input logic [3:0] exp_fb, input logic exp_fe);
    int busy_cycles;
    int cycles;
    logic exp_fv;
    mode = mode_in;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    busy_cycles = 0;
    cycles = 0;
    while (!done1 && cycles < 3000) begin
      if (busy1) busy_cycles++;
      @(posedge clk); #1;
      cycles++;
    end
    n_checks++;
    if (!done1 || busy_cycles != 512) begin
      n_fail++;
      $display("FAIL %s_busy_len: got done=%b busy_cycles=%0d, required done=1 busy_cycles=512",
               name, done1, busy_cycles);
    end
    n_checks++;
    if (err1 !== 9'(exp_err) || pass1 !== (exp_err == 0)) begin
      n_fail++;
      $display("FAIL %s_err: got err=%0d pass=%b, required err=%0d pass=%b",
               name, err1, pass1, exp_err, (exp_err == 0));
    end
    n_checks++;
    if (dut_a1 !== 4'd0 || dut_b1 !== 4'd0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_state: got a=%0d b=%0d busy=%b, required 0 0 0", name, dut_a1, dut_b1, busy1);
    end
`ifdef EQ_BIST_FIRST_FAIL_EN
    exp_fv = (exp_err != 0);
`else
    exp_fv = 1'b0;
    exp_fa = 4'd0;
    exp_fb = 4'd0;
    exp_fe = 1'b0;
`endif
    n_checks++;
    if (fail_valid1 !== exp_fv || fail_a1 !== exp_fa || fail_b1 !== exp_fb || fail_equal1 !== exp_fe) begin
      n_fail++;
      $display("FAIL %s_capture: got v=%b a=%0d b=%0d eq=%b, required v=%b a=%0d b=%0d eq=%b",
               name, fail_valid1, fail_a1, fail_b1, fail_equal1, exp_fv, exp_fa, exp_fb, exp_fe);
    end
  endtask

  task automatic test_reset_mid_sweep;
    mode = 0;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (99) @(posedge clk);
    #1 reset = 1'b1; start1 = 1'b1;
    @(posedge clk); #1 reset = 1'b0; start1 = 1'b0;
    n_checks++;
    if ({dut_a1, dut_b1, busy1, done1, pass1, err1, fail_valid1, fail_a1, fail_b1, fail_equal1} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy=%b done=%b err=%0d a=%0d b=%0d, required all 0",
               busy1, done1, err1, dut_a1, dut_b1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: got busy=%b done=%b, required 0 0", busy1, done1);
    end
    run_sweep("after_reset", 0, 0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic test_back_to_back;
    int cycles;
    mode = 1;
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    cycles = 0;
    while (!done3 && cycles < 3000) begin
      @(posedge clk); #1;
      cycles++;
      start3 = (cycles == 300);
    end
    start3 = 1'b0;
    n_checks++;
    if (!done3 || cycles != 1024) begin
      n_fail++;
      $display("FAIL s3_first_len: got done=%b cycles=%0d, required done=1 cycles=1024", done3, cycles);
    end
    n_checks++;
    if (err3 !== 9'd16 || pass3 !== 1'b0) begin
      n_fail++;
      $display("FAIL s3_first_err: got err=%0d pass=%b, required err=16 pass=0", err3, pass3);
    end
    mode = 0;
    repeat (4) @(posedge clk);
    #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    n_checks++;
    if (done3 !== 1'b0 || err3 !== 9'd0 || busy3 !== 1'b1) begin
      n_fail++;
      $display("FAIL s3_restart: got done=%b err=%0d busy=%b, required done=0 err=0 busy=1", done3, err3, busy3);
    end
    cycles = 0;
    while (!done3 && cycles < 3000) begin
      @(posedge clk); #1;
      cycles++;
    end
    n_checks++;
    if (!done3 || cycles != 1024 || pass3 !== 1'b1 || err3 !== 9'd0) begin
      n_fail++;
      $display("FAIL s3_second: got done=%b cycles=%0d pass=%b err=%0d, required 1 1024 1 0",
               done3, cycles, pass3, err3);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    run_sweep("good", 0, 0, 4'd0, 4'd0, 1'b0);
    run_sweep("stuck0", 1, 16, 4'd0, 4'd0, 1'b0);
    run_sweep("stuck1", 2, 240, 4'd0, 4'd1, 1'b1);
    run_sweep("inverted", 3, 256, 4'd0, 4'd0, 1'b0);
    test_reset_mid_sweep;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
